// File: rtl/ahb_bus_matrix_input_stage_s1_if.sv
// ----------------------------------------------------------------------------
// ahb_bus_matrix_input_stage_s1_if
// AHB slave-port signal bundle between an external AHB master and the S1
// input stage of the bus matrix.
//   master modport : drives address/control (HSELS..HAUSERS) and bus HREADYS,
//                    receives HREADYOUTS / HRESPS.
//   slave  modport : the input stage; the mirror image of master.
// ----------------------------------------------------------------------------
interface ahb_bus_matrix_input_stage_s1_if #(
  parameter int ADDR_W = 32,
  parameter int USER_W = 32
) ();
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic              HMASTLOCKS;
  logic [USER_W-1:0] HAUSERS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic [1:0]        HRESPS;

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HAUSERS, HREADYS,
    input  HREADYOUTS, HRESPS
  );

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HAUSERS, HREADYS,
    output HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/ahb_bus_matrix_input_stage_s1.sv
// ----------------------------------------------------------------------------
// ahb_bus_matrix_input_stage_s1
// Input stage for bus-matrix slave port S1. When the output stage selected by
// the decoder is not granting this port at an address phase, the transfer is
// captured, the master is stalled, and the captured transfer is replayed to
// the decoder until the output stage accepts it. Otherwise the address phase
// passes straight through with no added latency.
// Ports:
//   HCLK, HRESETn        : clock, asynchronous active-low reset
//   ahb (slave modport)  : AHB address/control from the master, ready/resp back
//   active_in            : output stage is granting this port
//   readyout_in, resp_in : data-phase ready/response from the decoder
//   sel_in .. auser_in   : address phase presented to the decoder
//   held_tran            : holding register occupied
// ----------------------------------------------------------------------------
module ahb_bus_matrix_input_stage_s1 #(
  parameter int ADDR_W = 32,
  parameter int USER_W = 32
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  ahb_bus_matrix_input_stage_s1_if.slave  ahb,
  input  logic                            active_in,
  input  logic                            readyout_in,
  input  logic [1:0]                      resp_in,
  output logic                            sel_in,
  output logic [ADDR_W-1:0]               addr_in,
  output logic [1:0]                      trans_in,
  output logic                            write_in,
  output logic [2:0]                      size_in,
  output logic [2:0]                      burst_in,
  output logic [3:0]                      prot_in,
  output logic                            lock_in,
  output logic [USER_W-1:0]               auser_in,
  output logic                            held_tran
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              trans_req_s;

  logic [ADDR_W-1:0] hold_addr_r;
  logic [1:0]        hold_trans_r;
  logic              hold_write_r;
  logic [2:0]        hold_size_r;
  logic [2:0]        hold_burst_r;
  logic [3:0]        hold_prot_r;
  logic              hold_lock_r;
  logic [USER_W-1:0] hold_auser_r;

  // A real transfer (NONSEQ/SEQ) is starting on this port this cycle.
  assign trans_req_s = ahb.HSELS & ahb.HTRANSS[1] & ahb.HREADYS;

  // Capture every starting transfer; only replayed if the stage enters HELD.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_addr_r  <= {ADDR_W{1'b0}};
      hold_trans_r <= 2'b00;
      hold_write_r <= 1'b0;
      hold_size_r  <= 3'b000;
      hold_burst_r <= 3'b000;
      hold_prot_r  <= 4'b0000;
      hold_lock_r  <= 1'b0;
      hold_auser_r <= {USER_W{1'b0}};
    end else if (trans_req_s) begin
      hold_addr_r  <= ahb.HADDRS;
      hold_trans_r <= ahb.HTRANSS;
      hold_write_r <= ahb.HWRITES;
      hold_size_r  <= ahb.HSIZES;
      hold_burst_r <= ahb.HBURSTS;
      hold_prot_r  <= ahb.HPROTS;
      hold_lock_r  <= ahb.HMASTLOCKS;
      hold_auser_r <= ahb.HAUSERS;
    end
  end

  // Hold-state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: a new ungranted transfer wins over acceptance of the held one.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (trans_req_s && !active_in) begin
          state_s = ST_HELD;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_HELD: begin
        if (trans_req_s && !active_in) begin
          state_s = ST_HELD;
        end else if (active_in && readyout_in) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_HELD;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  assign held_tran = (state_r == ST_HELD);

  // Decoder-side address mux and master-side response masking.
  always_comb begin
    sel_in         = ahb.HSELS;
    addr_in        = ahb.HADDRS;
    trans_in       = ahb.HTRANSS;
    write_in       = ahb.HWRITES;
    size_in        = ahb.HSIZES;
    burst_in       = ahb.HBURSTS;
    prot_in        = ahb.HPROTS;
    lock_in        = ahb.HMASTLOCKS;
    auser_in       = ahb.HAUSERS;
    ahb.HREADYOUTS = readyout_in;
    ahb.HRESPS     = resp_in;
    if (held_tran) begin
      sel_in         = 1'b1;
      addr_in        = hold_addr_r;
      trans_in       = hold_trans_r;
      write_in       = hold_write_r;
      size_in        = hold_size_r;
      burst_in       = hold_burst_r;
      prot_in        = hold_prot_r;
      lock_in        = hold_lock_r;
      auser_in       = hold_auser_r;
      ahb.HREADYOUTS = 1'b0;
      ahb.HRESPS     = 2'b00;
    end else begin
      ahb.HREADYOUTS = readyout_in;
      ahb.HRESPS     = resp_in;
    end
  end

endmodule

// File: tb/tb_ahb_bus_matrix_input_stage_s1.sv
module tb_ahb_bus_matrix_input_stage_s1;
  localparam int ADDR_W = 32;
  localparam int USER_W = 32;

  logic              HCLK;
  logic              HRESETn;
  logic              active_in;
  logic              readyout_in;
  logic [1:0]        resp_in;
  logic              sel_in;
  logic [ADDR_W-1:0] addr_in;
  logic [1:0]        trans_in;
  logic              write_in;
  logic [2:0]        size_in;
  logic [2:0]        burst_in;
  logic [3:0]        prot_in;
  logic              lock_in;
  logic [USER_W-1:0] auser_in;
  logic              held_tran;

  int tests_run;
  int tests_failed;

  ahb_bus_matrix_input_stage_s1_if #(.ADDR_W(ADDR_W), .USER_W(USER_W)) ahb ();

  ahb_bus_matrix_input_stage_s1 #(.ADDR_W(ADDR_W), .USER_W(USER_W)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .ahb         (ahb.slave),
    .active_in   (active_in),
    .readyout_in (readyout_in),
    .resp_in     (resp_in),
    .sel_in      (sel_in),
    .addr_in     (addr_in),
    .trans_in    (trans_in),
    .write_in    (write_in),
    .size_in     (size_in),
    .burst_in    (burst_in),
    .prot_in     (prot_in),
    .lock_in     (lock_in),
    .auser_in    (auser_in),
    .held_tran   (held_tran)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic drive_addr(input logic sel, input logic [1:0] trans,
                            input logic [31:0] addr, input logic wr,
                            input logic rdy);
    ahb.HSELS      = sel;
    ahb.HTRANSS    = trans;
    ahb.HADDRS     = addr;
    ahb.HWRITES    = wr;
    ahb.HREADYS    = rdy;
  endtask

  task automatic test_reset;
    HRESETn     = 1'b0;
    drive_addr(1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b1);
    ahb.HSIZES     = 3'b010;
    ahb.HBURSTS    = 3'b000;
    ahb.HPROTS     = 4'b0011;
    ahb.HMASTLOCKS = 1'b0;
    ahb.HAUSERS    = 32'h0000_0000;
    active_in   = 1'b1;
    readyout_in = 1'b1;
    resp_in     = 2'b00;
    repeat (2) @(negedge HCLK);
    #1;
    tests_run++;
    if (held_tran !== 1'b0) begin
      tests_failed++; $display("FAIL reset_held got=%b exp=0", held_tran);
    end
    tests_run++;
    if (trans_in !== 2'b00) begin
      tests_failed++; $display("FAIL reset_trans got=%b exp=00", trans_in);
    end
    tests_run++;
    if (ahb.HREADYOUTS !== 1'b1 || ahb.HRESPS !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ready got=%b/%b exp=1/00", ahb.HREADYOUTS, ahb.HRESPS);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_pass_through;
    @(negedge HCLK);
    drive_addr(1'b1, 2'b10, 32'h0000_0100, 1'b1, 1'b1);
    active_in   = 1'b1;
    readyout_in = 1'b1;
    #1;
    tests_run++;
    if (addr_in !== 32'h0000_0100 || sel_in !== 1'b1 || write_in !== 1'b1 ||
        trans_in !== 2'b10) begin
      tests_failed++;
      $display("FAIL pass_addr got=%h sel=%b wr=%b tr=%b exp=00000100/1/1/10",
               addr_in, sel_in, write_in, trans_in);
    end
    @(negedge HCLK);
    drive_addr(1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b0);
    readyout_in = 1'b0;
    #1;
    tests_run++;
    if (held_tran !== 1'b0 || ahb.HREADYOUTS !== 1'b0) begin
      tests_failed++;
      $display("FAIL pass_dphase held=%b rdy=%b exp=0/0", held_tran, ahb.HREADYOUTS);
    end
    @(negedge HCLK);
    readyout_in = 1'b1;
    ahb.HREADYS = 1'b1;
    #1;
    tests_run++;
    if (held_tran !== 1'b0 || ahb.HREADYOUTS !== 1'b1) begin
      tests_failed++;
      $display("FAIL pass_done held=%b rdy=%b exp=0/1", held_tran, ahb.HREADYOUTS);
    end
  endtask

  task automatic test_no_hold_idle;
    // IDLE, BUSY, deselected, and stalled-bus NONSEQ with no grant: no hold.
    logic [1:0] tr [4]  = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic       sl [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       rd [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      drive_addr(sl[i], tr[i], 32'h2000_0000, 1'b0, rd[i]);
      active_in = 1'b0;
      @(negedge HCLK);
      drive_addr(1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b1);
      active_in = 1'b1;
      #1;
      tests_run++;
      if (held_tran !== 1'b0) begin
        tests_failed++; $display("FAIL no_hold_%0d held=%b exp=0", i, held_tran);
      end
    end
  endtask

  task automatic test_hold_replay;
    @(negedge HCLK);
    drive_addr(1'b1, 2'b10, 32'h1000_0040, 1'b0, 1'b1);
    ahb.HPROTS  = 4'b0011;
    ahb.HAUSERS = 32'hA5A5_0001;
    active_in   = 1'b0;
    readyout_in = 1'b1;
    #1;
    tests_run++;
    if (held_tran !== 1'b0 || addr_in !== 32'h1000_0040) begin
      tests_failed++;
      $display("FAIL hold_N held=%b addr=%h exp=0/10000040", held_tran, addr_in);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      ahb.HREADYS = 1'b0;
      resp_in     = 2'b01;
      if (c == 1) begin
        ahb.HADDRS  = 32'hDEAD_0000;
        ahb.HTRANSS = 2'b00;
        ahb.HPROTS  = 4'b1111;
        ahb.HAUSERS = 32'h0000_0000;
        ahb.HSELS   = 1'b0;
      end
      if (c == 2) begin
        active_in = 1'b1;
        readyout_in = 1'b1;
      end
      #1;
      tests_run++;
      if (held_tran !== 1'b1 || addr_in !== 32'h1000_0040 || trans_in !== 2'b10 ||
          sel_in !== 1'b1 || write_in !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_cyc%0d held=%b addr=%h tr=%b sel=%b wr=%b exp=1/10000040/10/1/0",
                 c, held_tran, addr_in, trans_in, sel_in, write_in);
      end
      tests_run++;
      if (ahb.HREADYOUTS !== 1'b0 || ahb.HRESPS !== 2'b00) begin
        tests_failed++;
        $display("FAIL hold_mask%0d rdy=%b resp=%b exp=0/00", c, ahb.HREADYOUTS, ahb.HRESPS);
      end
      tests_run++;
      if (prot_in !== 4'b0011 || auser_in !== 32'hA5A5_0001) begin
        tests_failed++;
        $display("FAIL hold_ctl%0d prot=%b auser=%h exp=0011/a5a50001", c, prot_in, auser_in);
      end
    end
    // Acceptance + 1: data phase of the replayed read, slave inserts a wait.
    @(negedge HCLK);
    resp_in     = 2'b00;
    readyout_in = 1'b0;
    #1;
    tests_run++;
    if (held_tran !== 1'b0 || ahb.HREADYOUTS !== 1'b0 || addr_in !== 32'hDEAD_0000) begin
      tests_failed++;
      $display("FAIL hold_acc1 held=%b rdy=%b addr=%h exp=0/0/dead0000",
               held_tran, ahb.HREADYOUTS, addr_in);
    end
    @(negedge HCLK);
    readyout_in = 1'b1;
    drive_addr(1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (held_tran !== 1'b0 || ahb.HREADYOUTS !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_acc2 held=%b rdy=%b exp=0/1", held_tran, ahb.HREADYOUTS);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge HCLK);
    drive_addr(1'b1, 2'b10, 32'h1000_0040, 1'b0, 1'b1);
    active_in = 1'b0;
    @(negedge HCLK);
    ahb.HREADYS = 1'b0;
    active_in   = 1'b1;
    readyout_in = 1'b1;
    #1;
    tests_run++;
    if (held_tran !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_held held=%b exp=1", held_tran);
    end
    // Accepted at previous edge; SEQ presented while HREADY returns high.
    @(negedge HCLK);
    drive_addr(1'b1, 2'b11, 32'h1000_0044, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (held_tran !== 1'b0 || addr_in !== 32'h1000_0044 || trans_in !== 2'b11 ||
        ahb.HREADYOUTS !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_seq held=%b addr=%h tr=%b rdy=%b exp=0/10000044/11/1",
               held_tran, addr_in, trans_in, ahb.HREADYOUTS);
    end
    @(negedge HCLK);
    drive_addr(1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (held_tran !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_nohold held=%b exp=0", held_tran);
    end
  endtask

  task automatic test_error;
    logic r [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      resp_in     = 2'b01;
      readyout_in = r[i];
      #1;
      tests_run++;
      if (ahb.HRESPS !== 2'b01 || ahb.HREADYOUTS !== r[i]) begin
        tests_failed++;
        $display("FAIL err_cyc%0d resp=%b rdy=%b exp=01/%b", i, ahb.HRESPS, ahb.HREADYOUTS, r[i]);
      end
    end
    @(negedge HCLK);
    resp_in     = 2'b00;
    readyout_in = 1'b1;
  endtask

  task automatic test_reset_mid_hold;
    @(negedge HCLK);
    drive_addr(1'b1, 2'b10, 32'h3000_0000, 1'b1, 1'b1);
    active_in = 1'b0;
    @(negedge HCLK);
    drive_addr(1'b1, 2'b00, 32'h3000_0000, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (held_tran !== 1'b1 || trans_in !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_pre held=%b tr=%b exp=1/10", held_tran, trans_in);
    end
    #1;
    HRESETn = 1'b0;
    #1;
    tests_run++;
    if (held_tran !== 1'b0 || trans_in !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_async held=%b tr=%b exp=0/00", held_tran, trans_in);
    end
    @(negedge HCLK);
    HRESETn   = 1'b1;
    active_in = 1'b1;
    ahb.HREADYS = 1'b1;
    repeat (2) @(negedge HCLK);
    #1;
    tests_run++;
    if (held_tran !== 1'b0 || trans_in !== 2'b00 || addr_in !== 32'h3000_0000) begin
      tests_failed++;
      $display("FAIL rst_noreplay held=%b tr=%b addr=%h exp=0/00/30000000",
               held_tran, trans_in, addr_in);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset;
    test_pass_through;
    test_no_hold_idle;
    test_hold_replay;
    test_back_to_back;
    test_error;
    test_reset_mid_hold;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ahb_bus_matrix_input_stage_s1.md
# ahb_bus_matrix_input_stage_s1

Slave-port input stage for bus-matrix port S1, sitting between the external AHB master interface and the S1 address decoder. Registers an address phase that the selected output stage cannot accept immediately, holds the master in wait states until the output stage grants it, and replays the held transfer to the decoder. Returns decoder-supplied ready/response to the master, masked while a transfer is held.

## Interface
- ADDR_W, 32: address width (decoder consumes bits [31:10])
- USER_W, 32: HAUSER width
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSELS  in  1  port select from master side
- HADDRS  in  ADDR_W  address
- HTRANSS  in  2  transfer type
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst
- HPROTS  in  4  protection
- HMASTLOCKS  in  1  lock
- HAUSERS  in  USER_W  address-phase user
- HREADYS  in  1  bus HREADY seen by master
- active_in  in  1  selected output stage is granting this port (decoder active)
- readyout_in  in  1  data-phase HREADYOUT from decoder
- resp_in  in  2  data-phase HRESP from decoder
- sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in, lock_in, auser_in  out  1/ADDR_W/2/1/3/3/4/1/USER_W  address phase to decoder (held or pass-through)
- held_tran  out  1  holding register occupied
- HREADYOUTS  out  1  ready to master
- HRESPS  out  2  response to master

## Operation
- trans_req = HSELS & HTRANSS[1] & HREADYS.
- Holding register (all address/control fields) loads on every trans_req; no enable otherwise.
- held_tran: set when trans_req & ~active_in; cleared when held_tran & active_in & readyout_in (held transfer accepted by output stage); set dominates clear if both occur (cannot occur legally: HREADYS low while held).
- Mux: held_tran=1 -> all *_in outputs from holding register, sel_in=1; held_tran=0 -> pass-through of HSELS/HADDRS/.../HAUSERS.
- HREADYOUTS = held_tran ? 0 : readyout_in. HRESPS = held_tran ? 2'b00 : resp_in.
- Master changes to inputs while held_tran=1 are ignored (AHB requires them stable; IDLE/BUSY from master not forwarded).
- Decoder mapping unmapped addresses to default slave forces active_in=1, so such transfers never enter hold.
- Non-transfer cycles (IDLE/BUSY, HSELS=0) pass straight through; held_tran unaffected.
- States: EMPTY (held_tran=0), HELD (held_tran=1). EMPTY->HELD on trans_req&~active_in; HELD->EMPTY on active_in&readyout_in.

## Timing
- Reset: held_tran=0, holding register all 0 (trans=IDLE); outputs therefore pass-through; HREADYOUTS/HRESPS follow readyout_in/resp_in.
- Zero added latency when active_in=1 at the address phase: combinational pass-through.
- Hold case: address phase at cycle N (active_in=0); held_tran=1 from N+1; HREADYOUTS=0 from N+1 until the cycle after acceptance; replayed address phase presented from N+1.
- Acceptance at cycle M (active_in&readyout_in); held_tran=0 at M+1; data phase of the held transfer begins M+1 with HREADYOUTS=readyout_in.
- Two-cycle ERROR from decoder passes unchanged (held_tran=0 during any data phase it reports).
- Reset asserted while HELD: held transfer discarded immediately, no replay after release.

## Test plan
- Granted pass-through: active_in=1, NONSEQ write 0x0000_0100 -> addr_in=0x0000_0100 same cycle, held_tran stays 0, HREADYOUTS=readyout_in.
- Hold and replay: active_in=0 at NONSEQ read 0x1000_0040, active_in=1 three cycles later -> held_tran=1 for 3 cycles, addr_in=0x1000_0040, trans_in=2'b10 throughout, HREADYOUTS=0, then 0 at acceptance+1.
- Master input change during hold: drive HADDRS=0xDEAD_0000 while held -> addr_in stays 0x1000_0040.
- Back-to-back: held NONSEQ then SEQ 0x1000_0044 accepted next -> second transfer passes through, no second hold.
- Error passthrough: resp_in=2'b01, readyout_in 0 then 1 -> HRESPS=2'b01 both cycles, HREADYOUTS 0 then 1.
- Reset mid-hold: assert HRESETn=0 while held -> held_tran=0, trans_in=2'b00 asynchronously; no replay after release.
